// File: rtl/mem_pkg.sv
// Shared definitions for the data memory path. The CPU-side memory controller
// imports this package too, so both ends agree on the transfer-size codes and
// on where the MMIO registers sit.
//   mem_type_e      : RISC-V funct3 load/store size codes
//   MMIO_*          : register offsets inside the 16-byte MMIO window
//   is_legal_type() : 1 for the five defined size codes
//   base_lanes()    : byte-lane mask for a size code at byte offset 0
package mem_pkg;

   typedef enum logic [2:0] {
      MT_B  = 3'b000,
      MT_H  = 3'b001,
      MT_W  = 3'b010,
      MT_BU = 3'b100,
      MT_HU = 3'b101
   } mem_type_e;

   localparam logic [3:0] MMIO_GPIO  = 4'h0;
   localparam logic [3:0] MMIO_CYCLE = 4'h4;
   localparam logic [3:0] MMIO_STCNT = 4'h8;
   localparam logic [3:0] MMIO_ERR   = 4'hC;

   function automatic logic is_legal_type(input logic [2:0] t);
      case (t)
         MT_B, MT_H, MT_W, MT_BU, MT_HU: is_legal_type = 1'b1;
         default:                        is_legal_type = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] base_lanes(input logic [2:0] t);
      case (t)
         MT_B, MT_BU: base_lanes = 4'b0001;
         MT_H, MT_HU: base_lanes = 4'b0011;
         MT_W:        base_lanes = 4'b1111;
         default:     base_lanes = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Load/store bus between the CPU memory stage and the data memory unit.
//   master : CPU side, drives address, store data, size and enables
//   slave  : memory side, returns combinational load data
interface data_mem_unit_if;
   logic [31:0] MEM_addr;
   logic [31:0] MEM_WR_out;
   logic [2:0]  MEM_type;
   logic        MEM_rd_en;
   logic        MEM_wr_en;
   logic [31:0] MEM_data;

   modport master (
      output MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
      input  MEM_data
   );

   modport slave (
      input  MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
      output MEM_data
   );
endinterface

// File: rtl/dmem_lane_ram.sv
// DEPTH_WORDS x 32 RAM with per-byte-lane write enable and asynchronous read.
//   CLK   : write clock
//   we    : byte-lane write enables, bit i writes wdata[8i+7:8i]
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : word at addr, combinational
// Contents are deliberately not reset.
module dmem_lane_ram #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           CLK,
   input  logic [3:0]                     we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge CLK) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_unit.sv
// Data memory unit: RAM plus a 16-byte MMIO window (GPIO, cycle counter,
// store counter, error register).
//   CLK      : clock
//   Reset    : synchronous active-low reset (RAM contents survive)
//   mem      : load/store bus, slave side; loads are combinational
//   gpio_out : GPIO output register
//   err_flag : sticky access-error flag
//   err_addr : address of the first faulting access since the last clear
module data_mem_unit
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic              CLK,
   input  logic              Reset,
   data_mem_unit_if.slave    mem,
   output logic [31:0]       gpio_out,
   output logic              err_flag,
   output logic [31:0]       err_addr
);

   localparam int IW = $clog2(DEPTH_WORDS);

   logic [1:0]    off;
   logic [IW-1:0] idx;
   logic [3:0]    reg_off;
   logic          is_mmio;
   logic          misalign;
   logic          access_err;
   logic          ok_rd;
   logic          ok_wr;
   logic          ram_store;
   logic [3:0]    ram_we;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_q;
   logic [31:0]   ram_rot;
   logic [31:0]   mmio_q;
   logic [31:0]   cycle_q;
   logic [31:0]   stcnt_q;

   assign off     = mem.MEM_addr[1:0];
   assign idx     = mem.MEM_addr[IW+1:2];
   assign reg_off = {mem.MEM_addr[3:2], 2'b00};
   assign is_mmio = (mem.MEM_addr[31:4] == MMIO_BASE[31:4]);

   always_comb begin
      misalign = 1'b0;
      case (mem.MEM_type)
         MT_H, MT_HU: misalign = off[0];
         MT_W:        misalign = (off != 2'b00);
         default:     misalign = 1'b0;
      endcase
   end

   assign access_err = (mem.MEM_rd_en | mem.MEM_wr_en) &
                       ((mem.MEM_rd_en & mem.MEM_wr_en) |
                        !is_legal_type(mem.MEM_type) |
                        misalign |
                        (is_mmio & (mem.MEM_type != MT_W)));

   assign ok_rd     = mem.MEM_rd_en & !access_err;
   assign ok_wr     = mem.MEM_wr_en & !access_err;
   assign ram_store = ok_wr & !is_mmio;

   // Gating with Reset discards a store presented on a reset edge.
   assign ram_we    = (ram_store & Reset) ? (base_lanes(mem.MEM_type) << off) : 4'b0000;
   assign ram_wdata = mem.MEM_WR_out << {off, 3'b000};

   dmem_lane_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .CLK   (CLK),
      .we    (ram_we),
      .addr  (idx),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   // Rotate so the addressed byte/half lands at bit 0; extension is the CPU's job.
   always_comb begin
      ram_rot = ram_q;
      case (off)
         2'd0: ram_rot = ram_q;
         2'd1: ram_rot = {ram_q[7:0],  ram_q[31:8]};
         2'd2: ram_rot = {ram_q[15:0], ram_q[31:16]};
         2'd3: ram_rot = {ram_q[23:0], ram_q[31:24]};
         default: ram_rot = ram_q;
      endcase
   end

   always_comb begin
      mmio_q = 32'd0;
      case (reg_off)
         MMIO_GPIO:  mmio_q = gpio_out;
         MMIO_CYCLE: mmio_q = cycle_q;
         MMIO_STCNT: mmio_q = stcnt_q;
         MMIO_ERR:   mmio_q = {31'd0, err_flag};
         default:    mmio_q = 32'd0;
      endcase
   end

   assign mem.MEM_data = ok_rd ? (is_mmio ? mmio_q : ram_rot) : 32'd0;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         gpio_out <= 32'd0;
         cycle_q  <= 32'd0;
         stcnt_q  <= 32'd0;
         err_flag <= 1'b0;
         err_addr <= 32'd0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (ram_store) stcnt_q <= stcnt_q + 32'd1;
         if (ok_wr && is_mmio && reg_off == MMIO_GPIO) gpio_out <= mem.MEM_WR_out;
         // An ERR-register clear wins over any error raised in the same cycle.
         if (ok_wr && is_mmio && reg_off == MMIO_ERR) begin
            err_flag <= 1'b0;
            err_addr <= 32'd0;
         end else if (access_err && !err_flag) begin
            err_flag <= 1'b1;
            err_addr <= mem.MEM_addr;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;
   import mem_pkg::*;

   localparam logic [31:0] MB = 32'hFFFF_0000;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] gpio_out;
   logic        err_flag;
   logic [31:0] err_addr;

   data_mem_unit_if bus();

   data_mem_unit #(.DEPTH_WORDS(256), .MMIO_BASE(MB)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .mem      (bus),
      .gpio_out (gpio_out),
      .err_flag (err_flag),
      .err_addr (err_addr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;

   // Monitor: every cycle with a load presented, pop one expected value.
   always @(negedge CLK) begin
      if (!done && bus.MEM_rd_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_load actual=%h required=<no entry>", bus.MEM_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.MEM_data !== e.val) begin
               failures++;
               $display("FAIL %s actual=%h required=%h", e.name, bus.MEM_data, e.val);
            end
         end
      end
   end

   task automatic drive(input logic rd, input logic wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ex, input string nm);
      bus.MEM_rd_en  = rd;
      bus.MEM_wr_en  = wr;
      bus.MEM_type   = t;
      bus.MEM_addr   = a;
      bus.MEM_WR_out = d;
      if (rd) exp_q.push_back('{nm, ex});
   endtask

   task automatic op(input logic rd, input logic wr, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ex, input string nm);
      @(posedge CLK); #1;
      drive(rd, wr, t, a, d, ex, nm);
   endtask

   task automatic st(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
      op(1'b0, 1'b1, t, a, d, 32'd0, "");
   endtask

   task automatic ld(input logic [2:0] t, input logic [31:0] a,
                     input logic [31:0] ex, input string nm);
      op(1'b1, 1'b0, t, a, 32'd0, ex, nm);
   endtask

   task automatic idle();
      op(1'b0, 1'b0, MT_W, 32'd0, 32'd0, 32'd0, "");
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, ex);
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, MT_W, 32'd0, 32'd0, 32'd0, "");
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_gpio", gpio_out, 32'd0);
      chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      // First cycle with Reset high: CYCLE still 0, then 1.
      Reset = 1'b1;
      drive(1'b1, 1'b0, MT_W, MB + 32'h4, 32'd0, 32'd0, "cycle_first");
      ld(MT_W, MB + 32'h4, 32'd1, "cycle_second");

      // Byte/half merge into a zeroed word; three RAM stores.
      st(MT_W, 32'h20, 32'h0);
      st(MT_B, 32'h21, 32'hAA);
      st(MT_H, 32'h22, 32'h1234);
      ld(MT_W, 32'h20, 32'h1234AA00, "lw_0x20_merged");
      ld(MT_W, MB + 32'h8, 32'd3, "stcnt_3");
      ld(MT_HU, 32'h22, 32'hAA001234, "lhu_0x22_rot16");
      ld(MT_BU, 32'h21, 32'h001234AA, "lbu_0x21_rot8");

      // Store then immediate load; byte load rotates DE down to bit 0.
      st(MT_W, 32'h10, 32'hDEADBEEF);
      ld(MT_W, 32'h10, 32'hDEADBEEF, "lw_0x10");
      ld(MT_B, 32'h13, 32'hADBEEFDE, "lb_0x13");
      ld(MT_W, 32'h410, 32'hDEADBEEF, "lw_wrap_0x410");

      // Misaligned half load, then a misaligned word store keeps err_addr.
      ld(MT_H, 32'h21, 32'd0, "lh_misaligned");
      ld(MT_W, 32'h20, 32'h1234AA00, "lw_0x20_again");
      chk("err_flag_set", {31'd0, err_flag}, 32'd1);
      chk("err_addr_0x21", err_addr, 32'h21);
      op(1'b0, 1'b1, MT_W, 32'h23, 32'hFFFF_FFFF, 32'd0, "");
      ld(MT_W, MB + 32'hC, 32'd1, "err_reg_read");
      chk("err_addr_held", err_addr, 32'h21);
      ld(MT_W, 32'h20, 32'h1234AA00, "lw_0x20_no_misaligned_write");
      st(MT_W, MB + 32'hC, 32'h0);
      idle();
      chk("err_flag_cleared", {31'd0, err_flag}, 32'd0);
      chk("err_addr_cleared", err_addr, 32'd0);

      // GPIO store stays out of RAM and STCNT.
      st(MT_W, 32'h0, 32'h11223344);
      ld(MT_W, MB + 32'h8, 32'd5, "stcnt_5_before_gpio");
      st(MT_W, MB, 32'h5);
      idle();
      chk("gpio_5", gpio_out, 32'h5);
      ld(MT_W, MB, 32'h5, "gpio_readback");
      ld(MT_W, 32'h0, 32'h11223344, "ram0_untouched");
      ld(MT_W, MB + 32'h8, 32'd5, "stcnt_5_after_gpio");

      // Read+write together: suppressed, load returns 0, error at 0x30.
      st(MT_W, 32'h30, 32'h77);
      op(1'b1, 1'b1, MT_W, 32'h30, 32'h1, 32'd0, "rdwr_data_zero");
      ld(MT_W, 32'h30, 32'h77, "ram30_unchanged");
      chk("rdwr_err_flag", {31'd0, err_flag}, 32'd1);
      chk("rdwr_err_addr", err_addr, 32'h30);

      // Byte access to MMIO is an error and does not touch GPIO.
      st(MT_W, MB + 32'hC, 32'h0);
      st(MT_B, MB, 32'hFF);
      idle();
      chk("mmio_byte_err_addr", err_addr, MB);
      chk("mmio_byte_gpio_kept", gpio_out, 32'h5);

      // Undefined size code is an error; store to CYCLE is silently ignored.
      st(MT_W, MB + 32'hC, 32'h0);
      ld(3'b011, 32'h40, 32'd0, "bad_type_zero");
      idle();
      chk("bad_type_err_addr", err_addr, 32'h40);
      st(MT_W, MB + 32'hC, 32'h0);
      st(MT_W, MB + 32'h4, 32'h1234);
      idle();
      chk("cycle_store_no_err", {31'd0, err_flag}, 32'd0);

      // Mid-stream reset with a store on the reset edge.
      ld(MT_H, 32'h21, 32'd0, "lh_misaligned_pre_reset");
      repeat (100) idle();
      @(posedge CLK); #1;
      Reset = 1'b0;
      drive(1'b0, 1'b1, MT_W, 32'h10, 32'h99, 32'd0, "");
      @(posedge CLK); #1;
      Reset = 1'b1;
      drive(1'b1, 1'b0, MT_W, MB + 32'h4, 32'd0, 32'd0, "cycle_after_reset");
      chk("gpio_after_reset", gpio_out, 32'd0);
      chk("err_flag_after_reset", {31'd0, err_flag}, 32'd0);
      ld(MT_W, 32'h10, 32'hDEADBEEF, "ram10_survives_reset");
      ld(MT_W, MB + 32'h8, 32'd0, "stcnt_after_reset");
      idle();
      @(negedge CLK);
      done = 1'b1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
